// File: rtl/vga_pkg.sv
// Shared display geometry, key indices and the sprite axis step helper.
// SPRITE_WRAP_EN selects wrap-around instead of clamping at the screen bounds.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int SPR_W    = 32;
   localparam int SPR_H    = 32;

   typedef enum int {
      KEY_UP    = 0,
      KEY_DOWN  = 1,
      KEY_LEFT  = 2,
      KEY_RIGHT = 3,
      KEY_COLOR = 4
   } key_idx_e;

   // One frame of motion on one axis; 11-bit math keeps the borrow
   // and carry visible so they never alias into the 10-bit result.
   function automatic logic [9:0] step_axis(
      input logic [9:0] pos,
      input logic       dec,
      input logic       inc,
      input logic [9:0] step,
      input logic [9:0] lim
   );
      logic [10:0] w_sum;
      logic [10:0] w_dif;
      w_sum = {1'b0, pos} + {1'b0, step};
      w_dif = {1'b0, pos} - {1'b0, step};
      step_axis = pos;
      if (dec && !inc) begin
`ifdef SPRITE_WRAP_EN
         step_axis = w_dif[10] ? lim : w_dif[9:0];
`else
         step_axis = w_dif[10] ? 10'd0 : w_dif[9:0];
`endif
      end else if (inc && !dec) begin
`ifdef SPRITE_WRAP_EN
         step_axis = (w_sum > {1'b0, lim}) ? 10'd0 : w_sum[9:0];
`else
         step_axis = (w_sum > {1'b0, lim}) ? lim : w_sum[9:0];
`endif
      end
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low push-button.
// Ports: i_clk, i_rst_n (sync, low), i_key_n raw; o_level pressed, o_press edge.
module key_debounce
   import vga_pkg::*;
#(
   parameter int DEB_CYCLES = 250000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key_n,
   output logic o_level,
   output logic o_press
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic          r_s1;
   logic          r_s2;
   logic [CW-1:0] r_cnt;
   logic          w_raw;

   assign w_raw = ~r_s2;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1    <= 1'b1;
         r_s2    <= 1'b1;
         r_cnt   <= '0;
         o_level <= 1'b0;
         o_press <= 1'b0;
      end else begin
         r_s1    <= i_key_n;
         r_s2    <= r_s1;
         o_press <= 1'b0;
         // Any cycle agreeing with the accepted level restarts the count.
         if (w_raw != o_level) begin
            if (r_cnt == CW'(DEB_CYCLES - 1)) begin
               r_cnt   <= '0;
               o_level <= w_raw;
               o_press <= w_raw;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/sprite_ctrl.sv
// Moves and recolours a sprite from debounced push-buttons once per frame.
// Ports: clk, rst (sync, low), key_n[4:0], frame_pulse -> spr_x/y/rgb, moving.
// Build option: SPRITE_WRAP_EN wraps the sprite at screen bounds.
module sprite_ctrl
   import vga_pkg::*;
#(
   parameter int DEB_CYCLES = 250000,
   parameter int STEP       = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] key_n,
   input  logic       frame_pulse,
   output logic [9:0] spr_x,
   output logic [9:0] spr_y,
   output logic [2:0] spr_rgb,
   output logic       moving
);

   localparam logic [9:0] X_LIM  = 10'(H_ACTIVE - SPR_W);
   localparam logic [9:0] Y_LIM  = 10'(V_ACTIVE - SPR_H);
   localparam logic [9:0] STEP_V = 10'(STEP);

   logic [4:0] w_lvl;
   logic [4:0] w_press;
   logic       w_unused;
   logic       w_tick;
   logic       r_fp_s1;
   logic       r_fp_s2;
   logic       r_fp_prev;
   logic       r_pend;

   for (genvar g = 0; g < 5; g++) begin : g_key
      key_debounce #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
         .i_clk  (clk),
         .i_rst_n(rst),
         .i_key_n(key_n[g]),
         .o_level(w_lvl[g]),
         .o_press(w_press[g])
      );
   end

   // Direction keys act on level only; their press strobes are not needed.
   assign w_unused = ^w_press[KEY_RIGHT:KEY_UP];

   assign w_tick = r_fp_prev & ~r_fp_s2;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fp_s1   <= 1'b1;
         r_fp_s2   <= 1'b1;
         r_fp_prev <= 1'b1;
         r_pend    <= 1'b0;
         spr_x     <= 10'd304;
         spr_y     <= 10'd224;
         spr_rgb   <= 3'b111;
         moving    <= 1'b0;
      end else begin
         r_fp_s1   <= frame_pulse;
         r_fp_s2   <= r_fp_s1;
         r_fp_prev <= r_fp_s2;
         moving    <= |w_lvl[KEY_RIGHT:KEY_UP];
         if (w_tick) begin
            spr_x <= step_axis(spr_x, w_lvl[KEY_LEFT],
                               w_lvl[KEY_RIGHT], STEP_V, X_LIM);
            spr_y <= step_axis(spr_y, w_lvl[KEY_UP],
                               w_lvl[KEY_DOWN], STEP_V, Y_LIM);
            if (r_pend)
               spr_rgb <= (spr_rgb == 3'd7) ? 3'd1 : spr_rgb + 3'd1;
            // A press landing on the tick itself waits for the next one.
            r_pend <= w_press[KEY_COLOR];
         end else if (w_press[KEY_COLOR]) begin
            r_pend <= 1'b1;
         end
      end
   end

endmodule

// File: doc/sprite_ctrl.md
SPRITE_CTRL -- requirements
Module: sprite_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 250000, meaning consecutive stable cycles required to accept a key change (10 ms at 25 MHz).
REQ-002 SHALL have parameter STEP, default 4, meaning pixels moved per frame per held direction.
REQ-003 SHALL have port clk, input, 1 bit: 25 MHz pixel clock, the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port key_n, input, 5 bits: raw asynchronous push-buttons, active-low; [0] up, [1] down, [2] left, [3] right, [4] colour.
REQ-006 SHALL have port frame_pulse, input, 1 bit: vsync from the sync generator, active-low.
REQ-007 SHALL have port spr_x, output, 10 bits: sprite left edge in pixels.
REQ-008 SHALL have port spr_y, output, 10 bits: sprite top edge in pixels.
REQ-009 SHALL have port spr_rgb, output, 3 bits: sprite colour {r,g,b} consumed by the pixel generator.
REQ-010 SHALL have port moving, output, 1 bit: high while any direction key is debounced-pressed.

Function
REQ-011 Each key_n bit SHALL pass a 2-flop synchronizer before any use.
REQ-012 Debounced state SHALL change only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any glitch restarts the count.
REQ-013 A one-cycle frame tick SHALL fire on the falling edge of synchronized frame_pulse, and only there.
REQ-014 On a tick with left pressed and right not pressed, spr_x SHALL become max(0, spr_x-STEP); right alone SHALL give min(H_ACTIVE-SPR_W, spr_x+STEP).
REQ-015 Up/down SHALL update spr_y identically, against bound V_ACTIVE-SPR_H.
REQ-016 Opposing keys held together, or no key, SHALL leave that axis unchanged.
REQ-017 spr_x/spr_y SHALL change only in the cycle after a tick, so they are stable throughout active video.
REQ-018 A debounced press edge of key 4 SHALL set a pending flag; on the next tick spr_rgb SHALL step 1..7 cyclically (7 wraps to 1; 0 is never produced) and the flag SHALL clear.
REQ-019 Multiple colour presses within one frame SHALL yield a single step.
REQ-020 A press edge coinciding with a tick SHALL be applied on the following tick.
REQ-021 Arithmetic SHALL use 11-bit intermediates so no underflow or overflow aliasing reaches the outputs.
REQ-022 moving SHALL be a registered OR of the four debounced direction states.

Reset
REQ-023 While rst is low at a clk edge, the block SHALL load spr_x=304, spr_y=224, spr_rgb=3'b111, moving=0.
REQ-024 While rst is low at a clk edge, the block SHALL set all debounced states to released, clear all counters and the pending flag, and clear the tick edge detector.
REQ-025 Reset asserted mid-debounce or mid-frame SHALL discard the partial state; no tick SHALL fire in the cycle reset releases.

Configuration
REQ-026 With SPRITE_WRAP_EN defined, a move past a bound SHALL wrap instead of clamp.
REQ-027 Under SPRITE_WRAP_EN, left with spr_x<STEP SHALL give spr_x=H_ACTIVE-SPR_W.
REQ-028 Under SPRITE_WRAP_EN, right with spr_x+STEP>H_ACTIVE-SPR_W SHALL give spr_x=0, and the y axis SHALL behave likewise.
REQ-029 Without SPRITE_WRAP_EN, clamping per REQ-014/015 SHALL apply and no wrap logic SHALL be synthesized.

Structure
REQ-030 Shared package vga_pkg SHALL hold H_ACTIVE=640, V_ACTIVE=480, SPR_W=32, SPR_H=32 and the key index constants KEY_UP/DOWN/LEFT/RIGHT/COLOR.
REQ-031 Sub-module key_debounce (synchronizer, counter, debounced level, press-edge strobe) SHALL be instantiated five times.

Verification (DEB_CYCLES=4, STEP=4)
REQ-032 Reset, then hold right 10 frames -> spr_x=344, spr_y=224, moving=1 from 6 cycles after press.
REQ-033 2-cycle key_n[2] glitch -> no debounced change, spr_x unchanged across next tick.
REQ-034 spr_x=604, hold right 3 frames -> spr_x=608 (clamp); with SPRITE_WRAP_EN -> 608, 0, 4.
REQ-035 Three colour presses in one frame from spr_rgb=7 -> single step to 1 at next tick.
REQ-036 Left+right held 5 frames -> spr_x constant 304.
REQ-037 Reset asserted mid-frame after pending colour press -> spr_rgb=7 after the next tick, pending cleared.
